// File: rtl/alu_check_seq.sv
// alu_check_seq: sequences check vectors through an external 64-bit ALU.
// Each accepted command is registered onto the ALU operand bus, the ALU's
// combinational answer is compared one cycle later against the latched
// expectation, and pass/fail tallies plus the first failure are recorded.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous clear of tallies, index, first-fail and FSM
//   cmd_valid/ready     command handshake (ready only in IDLE without clear)
//   cmd_a/b/ctrl        ALU operands and control code
//   cmd_exp_result/zero expected ALU outputs
//   cmd_last            final command of a run (FSM parks in DONE after it)
//   alu_a/b/ctrl        registered drive to the ALU
//   alu_result/zero     combinational return from the ALU
//   pass_cnt/fail_cnt   saturating tallies
//   first_fail_*        index and ALU result of the first failing command
//   busy/done           FSM in EXEC / DONE
module alu_check_seq #(
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  input  logic [3:0]       cmd_ctrl,
  input  logic [63:0]      cmd_exp_result,
  input  logic             cmd_exp_zero,
  input  logic             cmd_last,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [63:0]      alu_result,
  input  logic             alu_zero,
  output logic [IDX_W-1:0] pass_cnt,
  output logic [IDX_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [63:0]      first_fail_result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [63:0]      alu_a_q, alu_a_d;
  logic [63:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [63:0]      exp_result_q, exp_result_d;
  logic             exp_zero_q, exp_zero_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic [IDX_W-1:0] fail_q, fail_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ff_valid_q, ff_valid_d;
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
  logic [63:0]      ff_result_q, ff_result_d;

  logic accept;
  logic check;
  logic pass_now;

  assign cmd_ready = (state_q == StIdle) && !clear;
  assign accept    = cmd_valid && cmd_ready;
  // The single EXEC cycle ends at the next edge; clear aborts it uncounted.
  assign check     = (state_q == StExec) && !clear;
  assign pass_now  = (alu_result == exp_result_q) && (alu_zero == exp_zero_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = last_q ? StDone : StIdle;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  always_comb begin
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    exp_result_d = exp_result_q;
    exp_zero_d   = exp_zero_q;
    last_d       = last_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    idx_d        = idx_q;
    ff_valid_d   = ff_valid_q;
    ff_idx_d     = ff_idx_q;
    ff_result_d  = ff_result_q;

    if (clear) begin
      pass_d      = '0;
      fail_d      = '0;
      idx_d       = '0;
      ff_valid_d  = 1'b0;
      ff_idx_d    = '0;
      ff_result_d = '0;
    end else begin
      if (accept) begin
        alu_a_d      = cmd_a;
        alu_b_d      = cmd_b;
        alu_ctrl_d   = cmd_ctrl;
        exp_result_d = cmd_exp_result;
        exp_zero_d   = cmd_exp_zero;
        last_d       = cmd_last;
      end
      if (check) begin
        if (pass_now) begin
          if (pass_q != '1) pass_d = pass_q + IDX_W'(1);
        end else begin
          if (fail_q != '1) fail_d = fail_q + IDX_W'(1);
          if (!ff_valid_q) begin
            ff_valid_d  = 1'b1;
            ff_idx_d    = idx_q;
            ff_result_d = alu_result;
          end
        end
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      exp_result_q <= '0;
      exp_zero_q   <= 1'b0;
      last_q       <= 1'b0;
      pass_q       <= '0;
      fail_q       <= '0;
      idx_q        <= '0;
      ff_valid_q   <= 1'b0;
      ff_idx_q     <= '0;
      ff_result_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      exp_result_q <= exp_result_d;
      exp_zero_q   <= exp_zero_d;
      last_q       <= last_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      idx_q        <= idx_d;
      ff_valid_q   <= ff_valid_d;
      ff_idx_q     <= ff_idx_d;
      ff_result_q  <= ff_result_d;
    end
  end

  assign alu_a             = alu_a_q;
  assign alu_b             = alu_b_q;
  assign alu_ctrl          = alu_ctrl_q;
  assign pass_cnt          = pass_q;
  assign fail_cnt          = fail_q;
  assign first_fail_valid  = ff_valid_q;
  assign first_fail_idx    = ff_idx_q;
  assign first_fail_result = ff_result_q;
  assign busy              = (state_q == StExec);
  assign done              = (state_q == StDone);

endmodule

// File: tb/tb_alu_check_seq.sv
// Scoreboard bench for alu_check_seq. A behavioural ALU closes the loop; the
// driver pushes hand-computed post-check state for each command, and a
// monitor pops and compares whenever the DUT leaves EXEC.
module tb_alu_check_seq;

  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [63:0]   cmd_a = '0, cmd_b = '0, cmd_exp_result = '0;
  logic [3:0]    cmd_ctrl = '0;
  logic          cmd_exp_zero = 1'b0, cmd_last = 1'b0;
  logic [63:0]   alu_a, alu_b, alu_result;
  logic [3:0]    alu_ctrl;
  logic          alu_zero;
  logic [IW-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic          first_fail_valid, busy, done;
  logic [63:0]   first_fail_result;

  always #5 clk = ~clk;

  alu_check_seq #(.IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctrl(cmd_ctrl),
    .cmd_exp_result(cmd_exp_result), .cmd_exp_zero(cmd_exp_zero), .cmd_last(cmd_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_result(first_fail_result), .busy(busy), .done(done)
  );

  // Behavioural alu_64bit.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0101: alu_result = alu_a << alu_b[5:0];
      4'b0111: alu_result = $signed(alu_a) >>> alu_b[5:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 64'd0);
  end

  typedef struct {
    logic [IW-1:0] pass;
    logic [IW-1:0] fail;
    logic          ffv;
    logic [IW-1:0] ffi;
    logic [63:0]   ffr;
    logic          dn;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  bit   skip = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input int p, input int f, input bit v, input int i,
                              input logic [63:0] r, input bit d);
    exp_t e;
    e.pass = IW'(p);
    e.fail = IW'(f);
    e.ffv  = v;
    e.ffi  = IW'(i);
    e.ffr  = r;
    e.dn   = d;
    return e;
  endfunction

  // Waits for ready at a falling edge, presents the command for one rising edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c,
                       input logic [63:0] er, input bit ez, input bit last,
                       input bit push, input exp_t e);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_a = a; cmd_b = b; cmd_ctrl = c;
    cmd_exp_result = er; cmd_exp_zero = ez; cmd_last = last;
    cmd_valid = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Monitor: one expectation per completed EXEC cycle.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        if (skip) begin
          skip = 1'b0;
        end else if (q.size() == 0) begin
          chk("unexpected_check", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("pass_cnt", 64'(pass_cnt), 64'(e.pass));
          chk("fail_cnt", 64'(fail_cnt), 64'(e.fail));
          chk("ff_valid", 64'(first_fail_valid), 64'(e.ffv));
          chk("ff_idx", 64'(first_fail_idx), 64'(e.ffi));
          chk("ff_result", first_fail_result, e.ffr);
          chk("done", 64'(done), 64'(e.dn));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    exp_t none;
    int t;
    none = mk(0, 0, 0, 0, 0, 0);

    // Reset state.
    #3;
    chk("rst_pass", 64'(pass_cnt), 0);
    chk("rst_fail", 64'(fail_cnt), 0);
    chk("rst_ffv", 64'(first_fail_valid), 0);
    chk("rst_ffr", first_fail_result, 0);
    chk("rst_busy_done", {62'd0, busy, done}, 0);
    chk("rst_alu_a", alu_a, 0);
    #19 rst_n = 1'b1;
    #1 chk("ready_after_rst", 64'(cmd_ready), 1);

    // idx0: ADD pass; ready drops for exactly one cycle.
    @(negedge clk);
    cmd_a = 64'd2; cmd_b = 64'd3; cmd_ctrl = 4'b0000;
    cmd_exp_result = 64'd5; cmd_exp_zero = 1'b0; cmd_last = 1'b0;
    cmd_valid = 1'b1;
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("ready_low_exec", {62'd0, cmd_ready, busy}, 64'b01);
    @(negedge clk);
    chk("ready_back", {62'd0, cmd_ready, busy}, 64'b10);

    // idx1..4
    issue(64'h0F, 64'hF0, 4'b0011, 64'hFF, 0, 0, 1, mk(2, 0, 0, 0, 0, 0));
    issue({16{4'hF, 4'h0}}, {16{4'h0, 4'hF}}, 4'b0010, '1, 0, 0, 1, mk(2, 1, 1, 2, 0, 0));
    issue(64'd1, 64'd4, 4'b0101, 64'h20, 0, 0, 1, mk(2, 2, 1, 2, 0, 0));
    issue(64'h8000_0000_0000_0000, 64'd4, 4'b0111, 64'hF800_0000_0000_0000, 0, 0, 1,
          mk(3, 2, 1, 2, 0, 0));

    // Clear in EXEC together with a new cmd_valid.
    issue(64'd7, 64'd8, 4'b0000, 64'd15, 0, 0, 0, none);
    @(negedge clk);
    skip = 1'b1;
    clear = 1'b1; cmd_valid = 1'b1; cmd_a = 64'd99;
    @(posedge clk);
    #1 clear = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("clr_counts", {56'd0, pass_cnt, fail_cnt}, 0);
    chk("clr_ffv", 64'(first_fail_valid), 0);
    chk("clr_idle", {62'd0, cmd_ready, busy}, 64'b10);
    chk("clr_not_accepted", alu_a, 64'd7);

    // SUB last -> DONE, further commands ignored.
    issue(64'd5, 64'd5, 4'b0001, 64'd0, 1, 1, 1, mk(1, 0, 0, 0, 0, 1));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 64'd42; cmd_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", {61'd0, done, cmd_ready, busy}, 64'b100);
    end
    cmd_valid = 1'b0;
    chk("done_alu_a", alu_a, 64'd5);
    chk("done_pass", 64'(pass_cnt), 1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("done_cleared", {60'd0, pass_cnt}, 0);
    chk("done_to_idle", {62'd0, done, cmd_ready}, 64'b01);

    // Asynchronous reset mid-EXEC.
    issue(64'd1, 64'd1, 4'b0000, 64'd2, 0, 0, 1, mk(1, 0, 0, 0, 0, 0));
    issue(64'd3, 64'd3, 4'b0000, 64'd6, 0, 0, 0, none);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pass", 64'(pass_cnt), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_alu", alu_a, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_count", {56'd0, pass_cnt, fail_cnt}, 0);

    // Saturation and index wrap: 17 passes, then failures.
    for (int i = 0; i < 17; i++) begin
      issue(64'(i), 64'd1, 4'b0000, 64'(i + 1), 0, 0, 1,
            mk((i + 1 > 15) ? 15 : i + 1, 0, 0, 0, 0, 0));
    end
    issue(64'hFF, 64'h0F, 4'b0010, 64'h10, 0, 0, 1, mk(15, 1, 1, 1, 64'h0F, 0));
    // Correct result but wrong zero expectation still fails.
    issue(64'd0, 64'd0, 4'b0000, 64'd0, 0, 0, 1, mk(15, 2, 1, 1, 64'h0F, 0));

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("queue_drained", 64'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
